// File: rtl/led_pattern_sched_pkg.sv
// Shared definitions for the LED pattern scheduler: slot geometry and FSM encoding.
// Pure declarations, no logic.
package led_pattern_sched_pkg;

    localparam int NUM_SLOTS         = 32;
    localparam int SLOT_IDX_BITS     = 5;
    localparam int SLOT_BITS_DEFAULT = 21;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    function automatic logic pattern_bit(input logic [NUM_SLOTS-1:0] pat,
                                         input logic [SLOT_IDX_BITS-1:0] slot);
        return pat[slot];
    endfunction

endpackage

// File: rtl/led_rr_arb2.sv
// Two-way round-robin grant, purely combinational (zero latency).
// Grants only inside a window; on a tie the requester that did not play last wins.
module led_rr_arb2
    import led_pattern_sched_pkg::*;
(
    input  logic window,
    input  logic valid0,
    input  logic valid1,
    input  logic last_owner,
    output logic ready0,
    output logic ready1,
    output logic winner
);

    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (window) begin
            if (valid0 && valid1) begin
                ready0 = last_owner;
                ready1 = ~last_owner;
            end else begin
                ready0 = valid0;
                ready1 = valid1;
            end
        end
        winner = ready1;
    end

endmodule

// File: rtl/led_pattern_sched.sv
// Plays 32-slot LED patterns from two requesters, heartbeat pattern when idle.
// Grant is taken in the same cycle as VALID; a playing frame is never cut short.
module led_pattern_sched
    import led_pattern_sched_pkg::*;
#(
    parameter int SLOT_BITS = SLOT_BITS_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 REQ0_VALID,
    input  logic                 REQ1_VALID,
    input  logic [NUM_SLOTS-1:0] REQ0_PATTERN,
    input  logic [NUM_SLOTS-1:0] REQ1_PATTERN,
    output logic                 REQ0_READY,
    output logic                 REQ1_READY,
    input  logic [NUM_SLOTS-1:0] IDLE_PATTERN,
    output logic                 LED,
    output logic                 BUSY,
    output logic                 OWNER,
    output logic                 DONE
);

    localparam int CNT_W = SLOT_BITS + SLOT_IDX_BITS;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0] pat_q, pat_d;
    logic                 owner_q, owner_d;
    logic                 last_owner_q, last_owner_d;

    logic                     frame_end;
    logic                     window;
    logic                     ready0;
    logic                     ready1;
    logic                     winner;
    logic                     xfer;
    logic [SLOT_IDX_BITS-1:0] slot;

    assign slot      = cnt_q[CNT_W-1:SLOT_BITS];
    assign frame_end = &cnt_q;
    // READY must read low while reset is held, even though the FSM sits in IDLE.
    assign window    = RESET_N && ((state_q == ST_IDLE) || frame_end);

    led_rr_arb2 u_arb (
        .window     (window),
        .valid0     (REQ0_VALID),
        .valid1     (REQ1_VALID),
        .last_owner (last_owner_q),
        .ready0     (ready0),
        .ready1     (ready1),
        .winner     (winner)
    );

    // The arbiter only raises a ready for a valid requester.
    assign xfer = ready0 | ready1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        pat_d        = pat_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        if (xfer) begin
            state_d      = ST_PLAY;
            cnt_d        = '0;
            pat_d        = winner ? REQ1_PATTERN : REQ0_PATTERN;
            owner_d      = winner;
            last_owner_d = winner;
        end else if ((state_q == ST_PLAY) && frame_end) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pat_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pat_q        <= pat_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign REQ0_READY = ready0;
    assign REQ1_READY = ready1;
    assign BUSY       = (state_q == ST_PLAY);
    assign OWNER      = owner_q;
    assign DONE       = BUSY && frame_end;
    assign LED        = BUSY ? pattern_bit(pat_q, slot) : pattern_bit(IDLE_PATTERN, slot);

endmodule

// File: tb/tb_led_pattern_sched.sv
// Randomised and directed bench for led_pattern_sched at SLOT_BITS=1 (64-cycle frame),
// checked against a frame-position reference model.
module tb_led_pattern_sched;

    localparam int SB    = 1;
    localparam int CPS   = 1 << SB;
    localparam int FRAME = 32 * CPS;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        REQ0_VALID, REQ1_VALID;
    logic [31:0] REQ0_PATTERN, REQ1_PATTERN;
    logic        REQ0_READY, REQ1_READY;
    logic [31:0] IDLE_PATTERN;
    logic        LED, BUSY, OWNER, DONE;

    int passed = 0;
    int total  = 0;

    // Reference model: whether a frame is playing, position within the frame,
    // the latched pattern, current and previous owner.
    logic        m_busy;
    int          m_pos;
    logic [31:0] m_pat;
    logic        m_owner;
    logic        m_last;

    always #5 CLK = ~CLK;

    led_pattern_sched #(.SLOT_BITS(SB)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .REQ0_VALID   (REQ0_VALID),
        .REQ1_VALID   (REQ1_VALID),
        .REQ0_PATTERN (REQ0_PATTERN),
        .REQ1_PATTERN (REQ1_PATTERN),
        .REQ0_READY   (REQ0_READY),
        .REQ1_READY   (REQ1_READY),
        .IDLE_PATTERN (IDLE_PATTERN),
        .LED          (LED),
        .BUSY         (BUSY),
        .OWNER        (OWNER),
        .DONE         (DONE)
    );

    // {LED, BUSY, OWNER, DONE, READY0, READY1}
    function automatic logic [5:0] model_out(input logic v0, input logic v1);
        logic win, r0, r1, led, last_cycle;
        int   slot;
        slot       = m_pos / CPS;
        last_cycle = m_busy && (m_pos == FRAME - 1);
        win        = !m_busy || last_cycle;
        r0         = win && v0 && (!v1 || m_last);
        r1         = win && v1 && (!v0 || !m_last);
        led        = m_busy ? m_pat[slot] : IDLE_PATTERN[slot];
        return {led, m_busy, m_owner, last_cycle, r0, r1};
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_pos   = 0;
        m_pat   = '0;
        m_owner = 1'b0;
        m_last  = 1'b1;
    endtask

    task automatic model_step(input logic v0, input logic v1,
                              input logic [31:0] p0, input logic [31:0] p1);
        logic [5:0] e;
        e = model_out(v0, v1);
        if (e[1] || e[0]) begin
            m_busy  = 1'b1;
            m_pos   = 0;
            m_pat   = e[1] ? p0 : p1;
            m_owner = e[0];
            m_last  = e[0];
        end else if (e[2]) begin
            m_busy = 1'b0;
            m_pos  = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    // Called just after a falling edge with inputs already set; returns at the next falling edge.
    task automatic run_cycle(output logic [5:0] obs, output logic [5:0] exp);
        #1;
        obs = {LED, BUSY, OWNER, DONE, REQ0_READY, REQ1_READY};
        exp = model_out(REQ0_VALID, REQ1_VALID);
        @(posedge CLK);
        model_step(REQ0_VALID, REQ1_VALID, REQ0_PATTERN, REQ1_PATTERN);
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET_N    = 1'b0;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [5:0] obs, exp;
        RESET_N      = 1'b0;
        REQ0_VALID   = 1'b0;
        REQ1_VALID   = 1'b0;
        REQ0_PATTERN = '0;
        REQ1_PATTERN = '0;
        IDLE_PATTERN = 32'h0000_0001;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        obs = {LED, BUSY, OWNER, DONE, REQ0_READY, REQ1_READY};
        total++;
        if (obs !== 6'b100000) $display("FAIL reset_state got %b want %b", obs, 6'b100000);
        else passed++;
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
        for (int k = 0; k < 130; k++) begin
            run_cycle(obs, exp);
            total++;
            if (obs !== exp) $display("FAIL idle_model k=%0d got %b want %b", k, obs, exp);
            else passed++;
            total++;
            if (obs[5:2] !== {((k % FRAME) < CPS), 3'b000})
                $display("FAIL idle_heartbeat k=%0d got %b want %b", k, obs[5:2], {((k % FRAME) < CPS), 3'b000});
            else passed++;
        end
    endtask

    task automatic test_single();
        logic [5:0] obs, exp;
        int         dones;
        REQ0_VALID   = 1'b1;
        REQ0_PATTERN = 32'hAAAA_AAAA;
        run_cycle(obs, exp);
        total++;
        if (obs[1:0] !== 2'b10) $display("FAIL single_ready got %b want 10", obs[1:0]);
        else passed++;
        REQ0_VALID = 1'b0;
        dones = 0;
        for (int k = 0; k < 70; k++) begin
            run_cycle(obs, exp);
            if (obs[2]) dones++;
            total++;
            if (obs !== exp) $display("FAIL single_model k=%0d got %b want %b", k, obs, exp);
            else passed++;
            if (k < FRAME) begin
                total++;
                if (obs[5:2] !== {logic'((k / CPS) % 2), 2'b10, logic'(k == FRAME - 1)})
                    $display("FAIL single_frame k=%0d got %b want %b", k, obs[5:2],
                             {logic'((k / CPS) % 2), 2'b10, logic'(k == FRAME - 1)});
                else passed++;
            end else if (k == FRAME) begin
                total++;
                if (obs[4] !== 1'b0) $display("FAIL single_back_idle got %b want 0", obs[4]);
                else passed++;
            end
        end
        total++;
        if (dones !== 1) $display("FAIL single_done_count got %0d want 1", dones);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] obs, exp;
        int         f;
        apply_reset();
        REQ0_VALID   = 1'b1;
        REQ1_VALID   = 1'b1;
        REQ0_PATTERN = 32'hFFFF_FFFF;
        REQ1_PATTERN = 32'h0000_0000;
        for (int k = 0; k < 1 + 4 * FRAME; k++) begin
            run_cycle(obs, exp);
            total++;
            if (obs !== exp) $display("FAIL b2b_model k=%0d got %b want %b", k, obs, exp);
            else passed++;
            total++;
            if (obs[1] && obs[0]) $display("FAIL b2b_both_ready k=%0d got 11 want at most one", k);
            else passed++;
            if (k == 0) begin
                total++;
                if (obs[1:0] !== 2'b10) $display("FAIL b2b_first_tie got %b want 10", obs[1:0]);
                else passed++;
            end else begin
                f = (k - 1) / FRAME;
                total++;
                if (obs[5:3] !== {logic'(f % 2 == 0), 1'b1, logic'(f % 2)})
                    $display("FAIL b2b_frame k=%0d got %b want %b", k, obs[5:3],
                             {logic'(f % 2 == 0), 1'b1, logic'(f % 2)});
                else passed++;
            end
        end
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
    endtask

    task automatic test_midframe();
        logic [5:0] obs, exp;
        apply_reset();
        REQ0_VALID   = 1'b1;
        REQ0_PATTERN = 32'h0F0F_0F0F;
        REQ1_PATTERN = 32'h1234_5678;
        run_cycle(obs, exp);
        REQ0_VALID = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            if (k == 10) REQ1_VALID = 1'b1;
            run_cycle(obs, exp);
            total++;
            if (obs !== exp) $display("FAIL mid_model k=%0d got %b want %b", k, obs, exp);
            else passed++;
            if (k >= 10) begin
                total++;
                if (obs[0] !== logic'(k == FRAME - 1))
                    $display("FAIL mid_ready1 k=%0d got %b want %b", k, obs[0], logic'(k == FRAME - 1));
                else passed++;
            end
            if (k == FRAME - 1) begin
                total++;
                if (obs[4:2] !== 3'b101) $display("FAIL mid_frame_done got %b want 101", obs[4:2]);
                else passed++;
            end
        end
        REQ1_VALID = 1'b0;
        for (int k = 0; k < 66; k++) begin
            run_cycle(obs, exp);
            total++;
            if (obs !== exp) $display("FAIL mid_next_model k=%0d got %b want %b", k, obs, exp);
            else passed++;
            if (k == 0) begin
                total++;
                if (obs[4:3] !== 2'b11) $display("FAIL mid_owner1 got %b want 11", obs[4:3]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [5:0] obs, exp;
        REQ0_VALID   = 1'b1;
        REQ0_PATTERN = 32'h0000_0000;
        run_cycle(obs, exp);
        REQ0_VALID = 1'b0;
        for (int k = 0; k < 30; k++) begin
            run_cycle(obs, exp);
            total++;
            if (obs !== exp) $display("FAIL rstmid_model k=%0d got %b want %b", k, obs, exp);
            else passed++;
        end
        REQ0_VALID   = 1'b1;
        REQ1_VALID   = 1'b1;
        REQ1_PATTERN = 32'hFFFF_0000;
        #2;
        RESET_N = 1'b0;
        #1;
        obs = {LED, BUSY, OWNER, DONE, REQ0_READY, REQ1_READY};
        total++;
        if (obs !== 6'b100000) $display("FAIL rstmid_async got %b want %b", obs, 6'b100000);
        else passed++;
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
        run_cycle(obs, exp);
        total++;
        if (obs[1:0] !== 2'b10) $display("FAIL rstmid_tie got %b want 10", obs[1:0]);
        else passed++;
        REQ0_VALID = 1'b0;
        for (int k = 0; k < 70; k++) begin
            run_cycle(obs, exp);
            total++;
            if (obs !== exp) $display("FAIL rstmid_after k=%0d got %b want %b", k, obs, exp);
            else passed++;
            if (exp[0]) REQ1_VALID = 1'b0;
        end
        REQ1_VALID = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] obs, exp;
        IDLE_PATTERN = $urandom;
        for (int k = 0; k < 800; k++) begin
            if (!REQ0_VALID && ($urandom_range(0, 15) == 0)) begin
                REQ0_VALID   = 1'b1;
                REQ0_PATTERN = $urandom;
            end
            if (!REQ1_VALID && ($urandom_range(0, 15) == 0)) begin
                REQ1_VALID   = 1'b1;
                REQ1_PATTERN = $urandom;
            end
            run_cycle(obs, exp);
            total++;
            if (obs !== exp) $display("FAIL random_model k=%0d got %b want %b", k, obs, exp);
            else passed++;
            if (exp[1]) REQ0_VALID = 1'b0;
            if (exp[0]) REQ1_VALID = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_midframe();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/led_pattern_sched.md
LED_PATTERN_SCHED -- requirements
Module: led_pattern_sched

Interface
REQ-001 Parameter: SLOT_BITS, default 21, log2 of clock cycles per pattern slot (131 ms at 16 MHz); legal range 1..24.
REQ-002 CLK  in  1  system clock, 16 MHz; all state on rising edge.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 REQ0_VALID / REQ1_VALID  in  1  requester 0/1 offers a pattern.
REQ-005 REQ0_PATTERN / REQ1_PATTERN  in  32  pattern offered; bit n drives slot n.
REQ-006 REQ0_READY / REQ1_READY  out  1  scheduler accepts the pattern this cycle.
REQ-007 IDLE_PATTERN  in  32  heartbeat pattern shown when no request is playing; quasi-static.
REQ-008 LED  out  1  LED drive.
REQ-009 BUSY  out  1  high while a granted pattern plays.
REQ-010 OWNER  out  1  index of the playing requester; meaningful only while BUSY.
REQ-011 DONE  out  1  one-cycle pulse on the last cycle of a granted frame.

Function
REQ-012 Frame = 32 slots x 2^SLOT_BITS cycles; counter width SLOT_BITS+5, wraps modulo; slot index = counter[SLOT_BITS+4:SLOT_BITS]; slot 0 (LSB) plays first.
REQ-013 States: IDLE, PLAY.
REQ-014 IDLE: counter free-runs; LED = IDLE_PATTERN[slot]; BUSY=0.
REQ-015 PLAY: LED = PAT[slot], where PAT is the latched 32-bit pattern; BUSY=1.
REQ-016 Grant window: any IDLE cycle, or the PLAY cycle where the counter is all ones (frame end).
REQ-017 In a grant window, READYx is asserted combinationally for at most one requester: the only valid one, or, if both are valid, the one not equal to LAST_OWNER.
REQ-018 Transfer occurs when VALIDx && READYx; on the next edge: PAT <= REQx_PATTERN, OWNER <= x, LAST_OWNER <= x, counter <= 0, state <= PLAY.
REQ-019 A frame is never truncated; a request arriving mid-frame waits for frame end with READY low.
REQ-020 At frame end in PLAY, DONE=1; if no request is valid, the next state is IDLE and the counter wraps to 0.
REQ-021 Back-to-back grants at frame end leave no IDLE gap; the new pattern's slot 0 starts on the next cycle.
REQ-022 Requesters hold VALID and PATTERN stable until READY; READY never depends on PATTERN.
REQ-023 LED, BUSY, OWNER and DONE are decoded from registered state only, without combinational paths from REQ inputs; READY is the sole combinational path from VALID.

Reset
REQ-024 RESET_N low immediately forces state=IDLE, counter=0, PAT=0, OWNER=0, LAST_OWNER=1, DONE=0, READY=0, BUSY=0, LED=IDLE_PATTERN[0], regardless of mid-frame activity.
REQ-025 After release, the first tie grants REQ0.

Structure
REQ-026 A shared package/include holds the state encoding, NUM_SLOTS=32 and SLOT_BITS default.
REQ-027 One sub-module, led_rr_arb2: a 2-way round-robin grant from (valid0, valid1, last_owner, window) -> (ready0, ready1, winner).

Verification (SLOT_BITS=1: 2 cycles/slot, 64-cycle frame)
REQ-028 Reset, no requests, IDLE_PATTERN=32'h0000_0001 -> LED=1 at counter 0-1, 0 at counter 2-63, repeating; BUSY=0, DONE never pulses.
REQ-029 REQ0_VALID with pattern 32'hAAAA_AAAA in IDLE -> REQ0_READY the same cycle; next cycle BUSY=1, OWNER=0; LED 0,0,1,1,... for 64 cycles; DONE on cycle 64; then IDLE.
REQ-030 Both VALID held, REQ0=32'hFFFF_FFFF, REQ1=32'h0 -> owners 0,1,0,1 in consecutive frames; LED constant 1 then 0 per frame; READY0 and READY1 never high together; no IDLE cycles.
REQ-031 REQ1_VALID raised at cycle 10 of a REQ0 frame -> REQ1_READY low until frame-end cycle 63; accepted there; REQ0 frame is complete.
REQ-032 RESET_N pulsed low at cycle 30 of a PLAY frame -> BUSY=0 and LED=IDLE_PATTERN[0] asynchronously; after release, a tie grants REQ0.
